// File: rtl/aes_spi_frame_ctrl.sv
// SPI byte-stream framer for a shared AES core: header, data block and key in,
// start/done handshake with the core, result block back out on later SPI bytes.
module aes_spi_frame_ctrl #(
  parameter int          BLOCK_BYTES = 16,
  parameter int          MAX_NK      = 8,
  parameter int          CNT_W       = 8,
  parameter logic [7:0]  ERR_BYTE    = 8'hEE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cs,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_byte,
  output logic [7:0]                tx_byte,
  output logic                      core_start,
  output logic                      core_mode,
  output logic [3:0]                core_nk,
  output logic [8*BLOCK_BYTES-1:0]  core_data,
  output logic [32*MAX_NK-1:0]      core_key,
  input  logic                      core_done,
  input  logic [8*BLOCK_BYTES-1:0]  core_result,
  output logic                      busy,
  output logic                      err,
  output logic                      frame_abort,
  output logic [CNT_W-1:0]          frame_count
);

  localparam int DW        = 8 * BLOCK_BYTES;
  localparam int KW        = 32 * MAX_NK;
  localparam int MAX_BYTES = (BLOCK_BYTES > 4 * MAX_NK) ? BLOCK_BYTES : 4 * MAX_NK;
  localparam int BCNT_W    = $clog2(MAX_BYTES) + 1;
  localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(BLOCK_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_HDR,
    S_RX_DATA,
    S_RX_KEY,
    S_WAIT_CORE,
    S_TX_DATA,
    S_ERROR
  } state_t;

  state_t            state_reg, state_next;
  logic [BCNT_W-1:0] byte_cnt_reg;
  logic [DW-1:0]     tx_shift_reg;
  logic              cs_prev_reg;
  logic              abort_pending_reg;

  logic              hdr_ok, hdr_bad, data_shift, key_shift, tx_shift;
  logic              start_now, abort_now, load_tx, frame_done;
  logic [3:0]        hdr_nk;
  logic              hdr_valid;
  logic [BCNT_W-1:0] key_last;
  logic              unused_rsvd;

  assign hdr_nk      = rx_byte[7:4];
  assign hdr_valid   = (hdr_nk == 4'd4 || hdr_nk == 4'd6 || hdr_nk == 4'd8) &&
                       (hdr_nk <= 4'(MAX_NK));
  // Key length always comes from the latched nk, never from the live byte.
  assign key_last    = BCNT_W'({core_nk, 2'b00}) - BCNT_W'(1);
  assign unused_rsvd = ^rx_byte[3:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    hdr_ok     = 1'b0;
    hdr_bad    = 1'b0;
    data_shift = 1'b0;
    key_shift  = 1'b0;
    tx_shift   = 1'b0;
    start_now  = 1'b0;
    abort_now  = 1'b0;
    load_tx    = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      S_IDLE: if (cs_prev_reg && !cs) state_next = S_RX_HDR;
      S_RX_HDR: begin
        if (cs) begin
          abort_now  = 1'b1;
          state_next = S_IDLE;
        end else if (rx_valid) begin
          if (hdr_valid) begin
            hdr_ok     = 1'b1;
            state_next = S_RX_DATA;
          end else begin
            hdr_bad    = 1'b1;
            state_next = S_ERROR;
          end
        end
      end
      S_RX_DATA: begin
        if (cs) begin
          abort_now  = 1'b1;
          state_next = S_IDLE;
        end else if (rx_valid) begin
          data_shift = 1'b1;
          if (byte_cnt_reg == DATA_LAST) state_next = S_RX_KEY;
        end
      end
      S_RX_KEY: begin
        if (cs) begin
          abort_now  = 1'b1;
          state_next = S_IDLE;
        end else if (rx_valid) begin
          key_shift = 1'b1;
          if (byte_cnt_reg == key_last) begin
            start_now  = 1'b1;
            state_next = S_WAIT_CORE;
          end
        end
      end
      S_WAIT_CORE: begin
        // An abort here must still swallow the core_done of this frame.
        if (core_done) begin
          if (abort_pending_reg || cs) begin
            abort_now  = 1'b1;
            state_next = S_IDLE;
          end else begin
            load_tx    = 1'b1;
            state_next = S_TX_DATA;
          end
        end
      end
      S_TX_DATA: begin
        if (cs) begin
          abort_now  = 1'b1;
          state_next = S_IDLE;
        end else if (rx_valid) begin
          tx_shift = 1'b1;
          if (byte_cnt_reg == DATA_LAST) begin
            frame_done = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      S_ERROR: if (cs) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt_reg      <= '0;
      tx_shift_reg      <= '0;
      cs_prev_reg       <= 1'b1;
      abort_pending_reg <= 1'b0;
      core_start        <= 1'b0;
      core_mode         <= 1'b0;
      core_nk           <= '0;
      core_data         <= '0;
      core_key          <= '0;
      err               <= 1'b0;
      frame_abort       <= 1'b0;
      frame_count       <= '0;
    end else begin
      cs_prev_reg <= cs;
      core_start  <= start_now;
      frame_abort <= abort_now;

      if (state_next != state_reg)               byte_cnt_reg <= '0;
      else if (data_shift || key_shift || tx_shift) byte_cnt_reg <= byte_cnt_reg + BCNT_W'(1);

      if (state_next != S_WAIT_CORE) abort_pending_reg <= 1'b0;
      else if (cs)                   abort_pending_reg <= 1'b1;

      if (hdr_ok) begin
        core_nk   <= hdr_nk;
        core_mode <= rx_byte[0];
        err       <= 1'b0;
        core_key  <= '0;
      end
      if (hdr_bad)    err <= 1'b1;
      if (data_shift) core_data <= {core_data[DW-9:0], rx_byte};
      if (key_shift)  core_key  <= {core_key[KW-9:0], rx_byte};

      if (load_tx)       tx_shift_reg <= core_result;
      else if (tx_shift) tx_shift_reg <= {tx_shift_reg[DW-9:0], 8'h00};

      if (frame_done) frame_count <= frame_count + CNT_W'(1);
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    case (state_reg)
      S_TX_DATA: tx_byte = tx_shift_reg[DW-1 -: 8];
      S_ERROR:   tx_byte = ERR_BYTE;
      default:   tx_byte = 8'h00;
    endcase
  end

  assign busy = (state_reg != S_IDLE);

endmodule

// File: tb/tb_aes_spi_frame_ctrl.sv
// Directed bench for aes_spi_frame_ctrl: FIPS-197 frames, bad header, abort,
// asynchronous reset mid-frame and frame counter wrap.
module tb_aes_spi_frame_ctrl;

  logic         clk, reset, cs, rx_valid, core_done;
  logic [7:0]   rx_byte, tx_byte;
  logic         core_start, core_mode, busy, err, frame_abort;
  logic [3:0]   core_nk;
  logic [127:0] core_data, core_result;
  logic [255:0] core_key;
  logic [7:0]   frame_count;

  int checks = 0;
  int errors = 0;
  int n_abort, n_start;
  logic [7:0] t;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] R128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] R192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] R256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_spi_frame_ctrl dut (
    .clk(clk), .reset(reset), .cs(cs), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_byte(tx_byte), .core_start(core_start), .core_mode(core_mode),
    .core_nk(core_nk), .core_data(core_data), .core_key(core_key),
    .core_done(core_done), .core_result(core_result), .busy(busy), .err(err),
    .frame_abort(frame_abort), .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One SPI byte; returns the tx_byte presented before this transfer.
  task automatic xfer(input logic [7:0] b, output logic [7:0] txo);
    @(negedge clk);
    txo      = tx_byte;
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic load_frame(input logic [7:0] hdr, input logic [127:0] pt,
                            input logic [255:0] key, input int nkb, input bit chk);
    logic [7:0] d;
    @(negedge clk);
    cs = 1'b0;
    @(negedge clk);
    xfer(hdr, d);
    if (chk) check("err_after_hdr", err, 1'b0);
    for (int i = 0; i < 16; i++) xfer(pt[127-8*i -: 8], d);
    for (int i = 0; i < nkb; i++) begin
      if (chk && i == nkb - 1) check("start_early", core_start, 1'b0);
      xfer(key[8*(nkb-i)-1 -: 8], d);
    end
  endtask

  task automatic expect_start(input logic [127:0] pt, input logic [255:0] key,
                              input logic mode, input logic [3:0] nk);
    int n;
    logic [7:0] d;
    n = 0;
    repeat (6) begin
      if (core_start === 1'b1) n++;
      @(negedge clk);
    end
    check("start_count", n, 1);
    check("core_nk", core_nk, nk);
    check("core_mode", core_mode, mode);
    check("core_data", core_data, pt);
    check("core_key", core_key, key);
    xfer(8'hA5, d);
    check("wait_tx", d, 8'h00);
    check("wait_busy", busy, 1'b1);
    check("wait_key_stable", core_key, key);
  endtask

  task automatic serve_core(input logic [127:0] res);
    @(negedge clk);
    core_result = res;
    core_done   = 1'b1;
    @(negedge clk);
    core_done   = 1'b0;
  endtask

  task automatic drain(input logic [127:0] res, input int n, input bit chk);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, d);
      if (chk) check("tx_byte", d, res[127-8*i -: 8]);
    end
  endtask

  task automatic run_frame(input logic [7:0] hdr, input logic [255:0] key, input int nkb,
                           input logic [127:0] res, input logic mode, input logic [3:0] nk,
                           input bit chk);
    load_frame(hdr, PT, key, nkb, chk);
    if (chk) expect_start(PT, key, mode, nk);
    serve_core(res);
    drain(res, 16, chk);
    if (chk) check("idle_after_frame", busy, 1'b0);
    @(negedge clk);
    cs = 1'b1;
    @(negedge clk);
    if (chk) $display("frame hdr=%02h nk=%0d frame_count=%0d", hdr, nk, frame_count);
  endtask

  initial begin
    reset = 1'b1; cs = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
    core_done = 1'b0; core_result = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx_byte, 8'h00);
    check("rst_ctrl", {core_start, core_mode, busy, err, frame_abort}, 5'b0);
    check("rst_nk", core_nk, 4'h0);
    check("rst_data", core_data, 128'h0);
    check("rst_key", core_key, 256'h0);
    check("rst_count", frame_count, 8'h0);
    reset = 1'b0;
    @(negedge clk);

    run_frame(8'h40, K128, 16, R128, 1'b0, 4'd4, 1'b1);
    check("count_f1", frame_count, 8'd1);

    run_frame(8'h81, K256, 32, R256, 1'b1, 4'd8, 1'b1);
    check("count_f2", frame_count, 8'd2);

    run_frame(8'h60, K192, 24, R192, 1'b0, 4'd6, 1'b1);
    check("key192_upper", core_key[255:192], 64'h0);
    check("count_f3", frame_count, 8'd3);

    // Bad header
    @(negedge clk); cs = 1'b0; @(negedge clk);
    xfer(8'h50, t);
    check("bad_hdr_err", err, 1'b1);
    check("bad_hdr_tx", tx_byte, 8'hEE);
    check("bad_hdr_busy", busy, 1'b1);
    xfer(8'h40, t);
    check("error_tx_before", t, 8'hEE);
    check("error_tx_after", tx_byte, 8'hEE);
    check("error_err_held", err, 1'b1);
    @(negedge clk); cs = 1'b1;
    n_abort = 0;
    repeat (4) begin @(negedge clk); if (frame_abort === 1'b1) n_abort++; end
    check("error_no_abort", n_abort, 0);
    check("error_exit_idle", busy, 1'b0);
    check("error_err_sticky", err, 1'b1);
    $display("frame hdr=50 rejected err=%0b", err);
    run_frame(8'h40, K128, 16, R128, 1'b0, 4'd4, 1'b1);
    check("err_cleared", err, 1'b0);
    check("count_f4", frame_count, 8'd4);

    // Abort after data byte 7
    @(negedge clk); cs = 1'b0; @(negedge clk);
    xfer(8'h40, t);
    for (int i = 0; i < 7; i++) xfer(PT[127-8*i -: 8], t);
    @(negedge clk); cs = 1'b1;
    n_abort = 0; n_start = 0;
    repeat (5) begin
      @(negedge clk);
      if (frame_abort === 1'b1) n_abort++;
      if (core_start === 1'b1) n_start++;
    end
    check("abort_pulses", n_abort, 1);
    check("abort_no_start", n_start, 0);
    check("abort_idle", busy, 1'b0);
    check("abort_count", frame_count, 8'd4);
    $display("frame aborted after 7 data bytes frame_count=%0d", frame_count);
    run_frame(8'h40, K128, 16, R128, 1'b0, 4'd4, 1'b1);
    check("count_f5", frame_count, 8'd5);

    // Asynchronous reset in the middle of TX_DATA
    load_frame(8'h40, PT, K128, 16, 1'b0);
    serve_core(R128);
    drain(R128, 3, 1'b1);
    #2 reset = 1'b1; cs = 1'b1;
    #1;
    check("areset_tx", tx_byte, 8'h00);
    check("areset_busy", busy, 1'b0);
    check("areset_count", frame_count, 8'h0);
    check("areset_data", core_data, 128'h0);
    check("areset_key", core_key, 256'h0);
    check("areset_ctrl", {core_start, core_mode, core_nk, err, frame_abort}, 8'h0);
    $display("reset asserted mid TX_DATA");
    @(negedge clk); reset = 1'b0;
    n_start = 0;
    repeat (3) begin @(negedge clk); if (core_start === 1'b1) n_start++; end
    check("areset_no_start", n_start, 0);
    run_frame(8'h40, K128, 16, R128, 1'b0, 4'd4, 1'b1);
    check("count_after_reset", frame_count, 8'd1);

    for (int f = 0; f < 255; f++) run_frame(8'h40, K128, 16, R128, 1'b0, 4'd4, 1'b0);
    check("count_wrap", frame_count, 8'd0);
    $display("255 frames run, frame_count=%0d", frame_count);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_spi_frame_ctrl.md
Name: aes_spi_frame_ctrl

Overview:
- Byte-stream frame controller between the SPI slave and a shared AES core; supports encrypt and decrypt with 128/192/256-bit keys.
- Frame layout: one header byte, then BLOCK_BYTES data bytes, then 4*NK key bytes. The controller starts the core with a start/done handshake and then returns the result block on the following SPI bytes.
- Adds header-selected mode, key-size validation, error reporting, frame-abort recovery and a frame counter.

Parameters:
- BLOCK_BYTES, 16, bytes per data block; the core data width is 8*BLOCK_BYTES.
- MAX_NK, 8, largest key length in 32-bit words; the key bus width is 32*MAX_NK.
- CNT_W, 8, width of frame_count.
- ERR_BYTE, 8'hEE, byte returned while in the ERROR state.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cs  in  1  SPI chip select, active low
- rx_valid  in  1  one-cycle pulse from the slave: a byte has completed
- rx_byte  in  8  received byte, valid while rx_valid is high
- tx_byte  out  8  byte the slave shifts out on the next transfer
- core_start  out  1  one-cycle start pulse to the AES core
- core_mode  out  1  0 = encrypt, 1 = decrypt
- core_nk  out  4  key length in words (4, 6 or 8)
- core_data  out  8*BLOCK_BYTES  input block to the core
- core_key  out  32*MAX_NK  key, right-aligned
- core_done  in  1  one-cycle pulse: core_result is valid
- core_result  in  8*BLOCK_BYTES  output block from the core
- busy  out  1  high in every state except IDLE
- err  out  1  sticky flag for a bad header; cleared on the next valid header
- frame_abort  out  1  one-cycle pulse when cs rises mid-frame
- frame_count  out  CNT_W  number of completed frames, wraps

Behaviour:
- Reset (asynchronous): state = IDLE, all counters 0, and every output 0: tx_byte, core_start, core_mode, core_nk, core_data, core_key, busy, err, frame_abort, frame_count. Asserting reset mid-frame discards the frame; no core_start is issued afterwards.
- State IDLE, with tx_byte = 0. When cs falls, go to RX_HDR.
- State RX_HDR, on rx_valid:
  - The header is {nk[7:4], rsvd[3:1], mode[0]}.
  - nk in {4,6,8}: latch core_nk and core_mode, clear err and core_key, go to RX_DATA.
  - Any other nk: set err and go to ERROR.
- State RX_DATA, on rx_valid:
  - The byte is shifted into core_data from the LSB end, so the first byte ends up in the MSB byte.
  - After BLOCK_BYTES bytes, go to RX_KEY.
- State RX_KEY, on rx_valid:
  - The byte is shifted into core_key from the LSB end, so the last key byte ends up in core_key[7:0].
  - The bits above 32*nk remain 0.
  - When the 4*nk-th byte arrives, pulse core_start on the next cycle and go to WAIT_CORE.
- State WAIT_CORE:
  - tx_byte = 8'h00; any rx_valid bytes are ignored (host dummy/poll bytes).
  - On core_done, latch core_result into the TX shift register, drive tx_byte = result MSB byte from the next cycle, and go to TX_DATA.
  - A core_done arriving in the same cycle as core_start is impossible: the core guarantees a latency of at least 1 cycle.
- State TX_DATA, on rx_valid:
  - Shift the result left by 8 and update tx_byte on the following cycle.
  - After BLOCK_BYTES bytes, increment frame_count (modulo 2^CNT_W) and go to IDLE, even if cs is still low.
- State ERROR:
  - tx_byte = ERR_BYTE and rx bytes are ignored.
  - Leave to IDLE only when cs rises; frame_abort does not pulse here.
- Abort: cs high while in RX_HDR, RX_DATA, RX_KEY or TX_DATA pulses frame_abort for 1 cycle and returns to IDLE; frame_count is unchanged.
- Abort during WAIT_CORE: state holds until core_done, the result is dropped, then return to IDLE with frame_abort pulsed. This prevents a later frame from receiving a stale core_done.
- rx_valid and a rising cs in the same cycle: the abort wins and the byte is discarded.
- Counter widths: the byte counter is clog2(max(BLOCK_BYTES, 4*MAX_NK)) + 1 bits. The key-length comparison uses the latched nk and never the live header.
- core_data, core_key, core_mode and core_nk are stable from core_start until core_done.

Test Plan:
- Header 0x40 + FIPS-197 C.1 plaintext 00112233..eeff + key 00010203..0f, core model returning 69c4e0d8..c55a → core_start fires once with core_nk = 4, core_mode = 0, core_key[127:0] = 000102..0f; tx bytes during TX_DATA are 69, c4, ..., 5a; frame_count goes 0→1.
- Header 0x81 with a 32-byte key → core_mode = 1, core_nk = 8, the full 256-bit key is latched, 16 result bytes are returned, then IDLE.
- Header 0x60 → after 24 key bytes core_start fires, core_key[255:192] = 0, and exactly 1 + 16 + 24 bytes are consumed before WAIT_CORE.
- Header 0x50 → err = 1 and tx_byte = 0xEE until cs rises; then a valid 0x40 frame clears err and completes normally.
- cs rises after data byte 7 → frame_abort pulses once, state is IDLE, no core_start, frame_count unchanged; the next full frame passes.
- reset asserted mid-TX_DATA (asynchronous, between clock edges) → all outputs 0 immediately; frame_count = 0; the next frame behaves from a clean state; 2^CNT_W frames wrap frame_count to 0.
